// File: rtl/bp_host_io_arbiter_if.sv
// Handshake bundle between the command requesters, the host I/O port and
// the arbiter. The arbiter connects through the slave modport; whatever
// drives the requesters and the host connects through the master modport.
interface bp_host_io_arbiter_if #(
    parameter int num_req_p   = 2,
    parameter int msg_width_p = 128
);
    // requester side
    logic [num_req_p*msg_width_p-1:0] req_cmd_i;
    logic [num_req_p-1:0]             req_cmd_v_i;
    logic [num_req_p-1:0]             req_cmd_yumi_o;
    logic [msg_width_p-1:0]           req_resp_o;
    logic [num_req_p-1:0]             req_resp_v_o;
    logic [num_req_p-1:0]             req_resp_yumi_i;

    // host side
    logic [msg_width_p-1:0]           io_cmd_o;
    logic                             io_cmd_v_o;
    logic                             io_cmd_ready_i;
    logic [msg_width_p-1:0]           io_resp_i;
    logic                             io_resp_v_i;
    logic                             io_resp_yumi_o;

    modport slave (
        input  req_cmd_i, req_cmd_v_i, req_resp_yumi_i,
        input  io_cmd_ready_i, io_resp_i, io_resp_v_i,
        output req_cmd_yumi_o, req_resp_o, req_resp_v_o,
        output io_cmd_o, io_cmd_v_o, io_resp_yumi_o
    );

    modport master (
        output req_cmd_i, req_cmd_v_i, req_resp_yumi_i,
        output io_cmd_ready_i, io_resp_i, io_resp_v_i,
        input  req_cmd_yumi_o, req_resp_o, req_resp_v_o,
        input  io_cmd_o, io_cmd_v_o, io_resp_yumi_o
    );
endinterface

// File: rtl/bp_host_io_arbiter.sv
// Host I/O arbiter: several requesters share one host command/response port.
// Commands are granted round-robin into a one-entry output register; the
// grantee index is recorded in an in-order tag FIFO so that host responses,
// which come back in command order, can be steered to their owner.
module bp_host_io_arbiter #(
    parameter int num_req_p         = 2,
    parameter int msg_width_p       = 128,
    parameter int max_outstanding_p = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_n_i,
    bp_host_io_arbiter_if.slave                    bus,
    output logic [$clog2(max_outstanding_p+1)-1:0] outstanding_o,
    output logic                                   orphan_resp_o
);
    localparam int tag_width_lp = $clog2(num_req_p);
    localparam int ptr_width_lp = $clog2(max_outstanding_p);
    localparam int cnt_width_lp = $clog2(max_outstanding_p + 1);
    localparam logic [cnt_width_lp-1:0] full_cnt_lp  = cnt_width_lp'(max_outstanding_p);
    localparam logic [tag_width_lp-1:0] last_rst_lp  = tag_width_lp'(num_req_p - 1);

    // registered state
    logic [msg_width_p-1:0]  cmd_r;
    logic                    cmd_v_r;
    logic [tag_width_lp-1:0] last_grant_r;
    logic [tag_width_lp-1:0] tag_mem_r [max_outstanding_p];
    logic [ptr_width_lp-1:0] wptr_r;
    logic [ptr_width_lp-1:0] rptr_r;
    logic [cnt_width_lp-1:0] count_r;
    logic                    orphan_r;

    // combinational decode
    logic                    load_ok_s;
    logic                    full_s;
    logic                    fifo_empty_s;
    logic                    grant_found_s;
    logic                    grant_v_s;
    logic [tag_width_lp-1:0] grant_idx_s;
    logic [tag_width_lp-1:0] cand_s;
    logic [msg_width_p-1:0]  cmd_sel_s;
    logic [tag_width_lp-1:0] head_tag_s;
    logic [num_req_p-1:0]    req_cmd_yumi_s;
    logic [num_req_p-1:0]    req_resp_v_s;
    logic                    io_resp_yumi_s;
    logic                    resp_pop_s;
    logic                    resp_orphan_s;

    assign load_ok_s    = ~cmd_v_r | bus.io_cmd_ready_i;
    // Full is judged on the registered count only, so a same-cycle pop never frees a slot early.
    assign full_s       = (count_r == full_cnt_lp);
    assign fifo_empty_s = (count_r == {cnt_width_lp{1'b0}});
    assign head_tag_s   = tag_mem_r[rptr_r];
    assign cmd_sel_s    = bus.req_cmd_i[int'(grant_idx_s) * msg_width_p +: msg_width_p];

    // Round-robin search starting just after the last grantee, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {tag_width_lp{1'b0}};
        cand_s        = {tag_width_lp{1'b0}};
        for (int k = 1; k <= num_req_p; k++) begin
            cand_s = tag_width_lp'((int'(last_grant_r) + k) % num_req_p);
            if (!grant_found_s && bus.req_cmd_v_i[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
            end else begin
                grant_found_s = grant_found_s;
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // Grant qualification and one-hot yumi; reset masks it asynchronously.
    always_comb begin
        req_cmd_yumi_s = {num_req_p{1'b0}};
        grant_v_s      = reset_n_i & load_ok_s & ~full_s & grant_found_s;
        if (grant_v_s) begin
            req_cmd_yumi_s[grant_idx_s] = 1'b1;
        end else begin
            req_cmd_yumi_s = {num_req_p{1'b0}};
        end
    end

    // Response steering: route to the head tag, or drop an orphan.
    always_comb begin
        req_resp_v_s   = {num_req_p{1'b0}};
        io_resp_yumi_s = 1'b0;
        resp_pop_s     = 1'b0;
        resp_orphan_s  = 1'b0;
        if (reset_n_i && bus.io_resp_v_i) begin
            if (fifo_empty_s) begin
                io_resp_yumi_s = 1'b1;
                resp_orphan_s  = 1'b1;
            end else begin
                req_resp_v_s[head_tag_s] = 1'b1;
                io_resp_yumi_s           = bus.req_resp_yumi_i[head_tag_s];
                resp_pop_s               = bus.req_resp_yumi_i[head_tag_s];
            end
        end else begin
            io_resp_yumi_s = 1'b0;
        end
    end

    // Output command register: load on grant, drain on host acceptance.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd_r        <= {msg_width_p{1'b0}};
            cmd_v_r      <= 1'b0;
            last_grant_r <= last_rst_lp;
        end else if (grant_v_s) begin
            cmd_r        <= cmd_sel_s;
            cmd_v_r      <= 1'b1;
            last_grant_r <= grant_idx_s;
        end else if (bus.io_cmd_ready_i) begin
            cmd_v_r      <= 1'b0;
        end else begin
            cmd_v_r      <= cmd_v_r;
        end
    end

    // Tag FIFO: push the grantee on grant, pop on the owner's response accept.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wptr_r  <= {ptr_width_lp{1'b0}};
            rptr_r  <= {ptr_width_lp{1'b0}};
            count_r <= {cnt_width_lp{1'b0}};
            for (int i = 0; i < max_outstanding_p; i++) begin
                tag_mem_r[i] <= {tag_width_lp{1'b0}};
            end
        end else begin
            if (grant_v_s) begin
                tag_mem_r[wptr_r] <= grant_idx_s;
                wptr_r            <= wptr_r + ptr_width_lp'(1);
            end
            if (resp_pop_s) begin
                rptr_r <= rptr_r + ptr_width_lp'(1);
            end
            case ({grant_v_s, resp_pop_s})
                2'b10:   count_r <= count_r + cnt_width_lp'(1);
                2'b01:   count_r <= count_r - cnt_width_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Sticky orphan-response flag, cleared only by reset.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            orphan_r <= 1'b0;
        end else if (resp_orphan_s) begin
            orphan_r <= 1'b1;
        end else begin
            orphan_r <= orphan_r;
        end
    end

    assign bus.req_cmd_yumi_o = req_cmd_yumi_s;
    assign bus.req_resp_o     = bus.io_resp_i;
    assign bus.req_resp_v_o   = req_resp_v_s;
    assign bus.io_resp_yumi_o = io_resp_yumi_s;
    assign bus.io_cmd_o       = cmd_r;
    assign bus.io_cmd_v_o     = cmd_v_r;
    assign outstanding_o      = count_r;
    assign orphan_resp_o      = orphan_r;
endmodule

// File: tb/tb_bp_host_io_arbiter.sv
// Bench for bp_host_io_arbiter: directed scenarios with literal expectations,
// then randomized traffic, all continuously checked against a queue-based model.
module tb_bp_host_io_arbiter;
    localparam int NREQ = 2;
    localparam int MW   = 128;
    localparam int OUTS = 8;
    localparam logic [MW-1:0] CMD0 = {4{32'hA0A0_0000}};
    localparam logic [MW-1:0] CMD1 = {4{32'hB1B1_1111}};

    logic clk_s     = 1'b0;
    logic reset_n_s = 1'b0;
    logic [3:0] outstanding_s;
    logic       orphan_s;

    int total = 0;
    int bad   = 0;

    bp_host_io_arbiter_if #(.num_req_p(NREQ), .msg_width_p(MW)) bus ();

    bp_host_io_arbiter #(
        .num_req_p(NREQ), .msg_width_p(MW), .max_outstanding_p(OUTS)
    ) dut (
        .clk_i(clk_s),
        .reset_n_i(reset_n_s),
        .bus(bus),
        .outstanding_o(outstanding_s),
        .orphan_resp_o(orphan_s)
    );

    always #5 clk_s = ~clk_s;

    task automatic chk(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int               m_q[$];
    bit               m_v;
    logic [MW-1:0]    m_cmd;
    int               m_last;
    bit               m_orphan;
    int               m_g;
    bit               m_pop;
    bit               m_orph_now;
    logic [NREQ-1:0]  e_yumi;
    logic [NREQ-1:0]  e_rv;
    bit               e_ry;

    task automatic model_reset();
        m_q.delete();
        m_v      = 1'b0;
        m_cmd    = '0;
        m_last   = NREQ - 1;
        m_orphan = 1'b0;
    endtask

    // Compare process: every falling edge, check outputs then advance the model.
    initial begin
        model_reset();
        forever begin
            @(negedge clk_s);
            if (!reset_n_s) begin
                model_reset();
                chk("rst_yumi", bus.req_cmd_yumi_o, '0);
                chk("rst_cmd_v", bus.io_cmd_v_o, '0);
                chk("rst_resp_v", bus.req_resp_v_o, '0);
                chk("rst_resp_yumi", bus.io_resp_yumi_o, '0);
                chk("rst_outstanding", outstanding_s, '0);
                chk("rst_orphan", orphan_s, '0);
            end else begin
                // grant decision from the rules
                m_g = -1;
                if ((!m_v || bus.io_cmd_ready_i) && (m_q.size() < OUTS)) begin
                    for (int k = 1; k <= NREQ; k++) begin
                        if (m_g < 0 && bus.req_cmd_v_i[(m_last + k) % NREQ])
                            m_g = (m_last + k) % NREQ;
                    end
                end
                e_yumi = '0;
                if (m_g >= 0) e_yumi[m_g] = 1'b1;
                // response routing
                e_rv = '0; e_ry = 1'b0; m_pop = 1'b0; m_orph_now = 1'b0;
                if (bus.io_resp_v_i) begin
                    if (m_q.size() > 0) begin
                        e_rv[m_q[0]] = 1'b1;
                        e_ry  = bus.req_resp_yumi_i[m_q[0]];
                        m_pop = e_ry;
                    end else begin
                        e_ry = 1'b1;
                        m_orph_now = 1'b1;
                    end
                end
                chk("m_yumi", bus.req_cmd_yumi_o, e_yumi);
                chk("m_cmd_v", bus.io_cmd_v_o, m_v);
                if (m_v) chk("m_cmd", bus.io_cmd_o, m_cmd);
                chk("m_resp_v", bus.req_resp_v_o, e_rv);
                chk("m_resp_yumi", bus.io_resp_yumi_o, e_ry);
                if (bus.io_resp_v_i) chk("m_resp_data", bus.req_resp_o, bus.io_resp_i);
                chk("m_outstanding", outstanding_s, m_q.size());
                chk("m_orphan", orphan_s, m_orphan);
                // advance model to the next cycle
                if (m_v && bus.io_cmd_ready_i) m_v = 1'b0;
                if (m_pop) void'(m_q.pop_front());
                if (m_g >= 0) begin
                    m_v    = 1'b1;
                    m_cmd  = bus.req_cmd_i[m_g*MW +: MW];
                    m_q.push_back(m_g);
                    m_last = m_g;
                end
                if (m_orph_now) m_orphan = 1'b1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic nxt();
        @(posedge clk_s);
        #1;
    endtask

    task automatic idle_inputs();
        bus.req_cmd_v_i     = '0;
        bus.req_resp_yumi_i = '0;
        bus.io_cmd_ready_i  = 1'b0;
        bus.io_resp_v_i     = 1'b0;
        bus.io_resp_i       = '0;
        bus.req_cmd_i       = {CMD1, CMD0};
    endtask

    task automatic do_reset();
        reset_n_s = 1'b0;
        idle_inputs();
        nxt();
        nxt();
        reset_n_s = 1'b1;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        nxt();
        do_reset();

        // Round-robin alternation with host always ready.
        bus.req_cmd_v_i = 2'b11; bus.io_cmd_ready_i = 1'b1;
        @(negedge clk_s);
        chk("rr_c0_yumi", bus.req_cmd_yumi_o, 2'b01);
        chk("rr_c0_cmd_v", bus.io_cmd_v_o, 1'b0);
        nxt(); @(negedge clk_s);
        chk("rr_c1_yumi", bus.req_cmd_yumi_o, 2'b10);
        chk("rr_c1_cmd_v", bus.io_cmd_v_o, 1'b1);
        chk("rr_c1_cmd", bus.io_cmd_o, CMD0);
        nxt(); @(negedge clk_s);
        chk("rr_c2_yumi", bus.req_cmd_yumi_o, 2'b01);
        chk("rr_c2_cmd", bus.io_cmd_o, CMD1);
        nxt(); @(negedge clk_s);
        chk("rr_c3_yumi", bus.req_cmd_yumi_o, 2'b10);
        nxt(); bus.req_cmd_v_i = 2'b00; @(negedge clk_s);
        chk("rr_outstanding", outstanding_s, 4'd4);
        nxt(); do_reset();

        // Host backpressure holds the register; ready releases it and regrants.
        bus.req_cmd_v_i = 2'b01; bus.io_cmd_ready_i = 1'b0;
        @(negedge clk_s);
        chk("bp_c0_yumi", bus.req_cmd_yumi_o, 2'b01);
        nxt(); @(negedge clk_s);
        chk("bp_c1_yumi", bus.req_cmd_yumi_o, 2'b00);
        chk("bp_c1_cmd_v", bus.io_cmd_v_o, 1'b1);
        nxt(); @(negedge clk_s);
        chk("bp_c2_yumi", bus.req_cmd_yumi_o, 2'b00);
        chk("bp_c2_cmd", bus.io_cmd_o, CMD0);
        nxt(); bus.io_cmd_ready_i = 1'b1; @(negedge clk_s);
        chk("bp_c3_yumi", bus.req_cmd_yumi_o, 2'b01);
        chk("bp_c3_cmd_v", bus.io_cmd_v_o, 1'b1);
        nxt(); do_reset();

        // Fill the tag FIFO, then free one slot.
        bus.req_cmd_v_i = 2'b01; bus.io_cmd_ready_i = 1'b1;
        repeat (8) nxt();
        @(negedge clk_s);
        chk("full_outstanding", outstanding_s, 4'd8);
        chk("full_no_grant", bus.req_cmd_yumi_o, 2'b00);
        nxt(); bus.io_resp_v_i = 1'b1; bus.req_resp_yumi_i = 2'b01; @(negedge clk_s);
        chk("full_pop_resp_v", bus.req_resp_v_o, 2'b01);
        chk("full_pop_yumi", bus.io_resp_yumi_o, 1'b1);
        chk("full_pop_no_grant", bus.req_cmd_yumi_o, 2'b00);
        nxt(); bus.io_resp_v_i = 1'b0; @(negedge clk_s);
        chk("full_after_outstanding", outstanding_s, 4'd7);
        chk("full_after_grant", bus.req_cmd_yumi_o, 2'b01);
        nxt(); do_reset();

        // Grants 1,0,1 then in-order response routing with a yumi stall.
        bus.io_cmd_ready_i = 1'b1;
        bus.req_cmd_v_i = 2'b10; @(negedge clk_s);
        chk("ord_g0", bus.req_cmd_yumi_o, 2'b10);
        nxt(); bus.req_cmd_v_i = 2'b01; @(negedge clk_s);
        chk("ord_g1", bus.req_cmd_yumi_o, 2'b01);
        nxt(); bus.req_cmd_v_i = 2'b10; @(negedge clk_s);
        chk("ord_g2", bus.req_cmd_yumi_o, 2'b10);
        nxt(); bus.req_cmd_v_i = 2'b00;
        bus.io_resp_v_i = 1'b1; bus.req_resp_yumi_i = 2'b11; bus.io_resp_i = {4{32'h5EED_0001}};
        @(negedge clk_s);
        chk("ord_r0_v", bus.req_resp_v_o, 2'b10);
        chk("ord_r0_yumi", bus.io_resp_yumi_o, 1'b1);
        chk("ord_r0_data", bus.req_resp_o, {4{32'h5EED_0001}});
        nxt(); @(negedge clk_s);
        chk("ord_r1_v", bus.req_resp_v_o, 2'b01);
        nxt(); bus.req_resp_yumi_i = 2'b01; @(negedge clk_s);
        chk("ord_stall_v", bus.req_resp_v_o, 2'b10);
        chk("ord_stall_yumi", bus.io_resp_yumi_o, 1'b0);
        nxt(); bus.req_resp_yumi_i = 2'b10; @(negedge clk_s);
        chk("ord_r2_v", bus.req_resp_v_o, 2'b10);
        chk("ord_r2_yumi", bus.io_resp_yumi_o, 1'b1);
        nxt(); bus.io_resp_v_i = 1'b0; @(negedge clk_s);
        chk("ord_drained", outstanding_s, 4'd0);
        nxt(); do_reset();

        // Orphan response with an empty FIFO.
        bus.io_resp_v_i = 1'b1; @(negedge clk_s);
        chk("orph_yumi", bus.io_resp_yumi_o, 1'b1);
        chk("orph_resp_v", bus.req_resp_v_o, 2'b00);
        nxt(); bus.io_resp_v_i = 1'b0; @(negedge clk_s);
        chk("orph_flag", orphan_s, 1'b1);
        nxt(); nxt(); @(negedge clk_s);
        chk("orph_held", orphan_s, 1'b1);
        nxt(); do_reset();

        // Asynchronous reset with three commands outstanding.
        bus.req_cmd_v_i = 2'b01; bus.io_cmd_ready_i = 1'b1;
        repeat (3) nxt();
        reset_n_s = 1'b0;
        #1;
        chk("ar_yumi", bus.req_cmd_yumi_o, 2'b00);
        chk("ar_cmd_v", bus.io_cmd_v_o, 1'b0);
        chk("ar_resp_v", bus.req_resp_v_o, 2'b00);
        chk("ar_resp_yumi", bus.io_resp_yumi_o, 1'b0);
        chk("ar_outstanding", outstanding_s, 4'd0);
        chk("ar_orphan", orphan_s, 1'b0);
        nxt(); nxt();
        reset_n_s = 1'b1; bus.req_cmd_v_i = 2'b11; @(negedge clk_s);
        chk("ar_first_grant", bus.req_cmd_yumi_o, 2'b01);
        nxt(); do_reset();

        // Randomized traffic checked by the model process.
        for (int n = 0; n < 3000; n++) begin
            bus.req_cmd_v_i     = NREQ'($urandom_range(0, 3));
            bus.req_cmd_i       = {$urandom, $urandom, $urandom, $urandom,
                                   $urandom, $urandom, $urandom, $urandom};
            bus.io_cmd_ready_i  = ($urandom_range(0, 3) != 0);
            bus.io_resp_v_i     = ($urandom_range(0, 2) == 0);
            bus.req_resp_yumi_i = NREQ'($urandom_range(0, 3));
            bus.io_resp_i       = {$urandom, $urandom, $urandom, $urandom};
            if ($urandom_range(0, 599) == 0) begin
                reset_n_s = 1'b0;
            end else begin
                reset_n_s = 1'b1;
            end
            nxt();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bp_host_io_arbiter.md
BP_HOST_IO_ARBITER -- requirements
Module: bp_host_io_arbiter

Interface
REQ-001 SHALL have parameter num_req_p, default 2: number of command requesters (cores) sharing one host I/O port; legal 2..16.
REQ-002 SHALL have parameter msg_width_p, default 128: width of one packed memory message (header plus data).
REQ-003 SHALL have parameter max_outstanding_p, default 8: capacity of the in-order tag FIFO; power of two, legal 2..32.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset_n_i, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port req_cmd_i, input, num_req_p*msg_width_p: per-requester command; slice i belongs to requester i.
REQ-007 SHALL have port req_cmd_v_i, input, num_req_p: per-requester command valid.
REQ-008 SHALL have port req_cmd_yumi_o, output, num_req_p: one-hot grant; the command is consumed this cycle.
REQ-009 SHALL have port req_resp_o, output, msg_width_p: response broadcast to all requesters.
REQ-010 SHALL have port req_resp_v_o, output, num_req_p: one-hot response valid, routed to the owning requester.
REQ-011 SHALL have port req_resp_yumi_i, input, num_req_p: per-requester response accept.
REQ-012 SHALL have port io_cmd_o, output, msg_width_p: command to the host.
REQ-013 SHALL have port io_cmd_v_o, output, 1: host command valid.
REQ-014 SHALL have port io_cmd_ready_i, input, 1: host command ready; a transfer occurs when io_cmd_v_o and io_cmd_ready_i are both high.
REQ-015 SHALL have port io_resp_i, input, msg_width_p: host response; the host returns responses in command order.
REQ-016 SHALL have port io_resp_v_i, input, 1: host response valid.
REQ-017 SHALL have port io_resp_yumi_o, output, 1: host response consumed.
REQ-018 SHALL have port outstanding_o, output, clog2(max_outstanding_p+1): current tag FIFO occupancy.
REQ-019 SHALL have port orphan_resp_o, output, 1: sticky flag; set when a response arrives with no outstanding command.

Function
REQ-020 SHALL hold a one-entry output register (io_cmd_o, io_cmd_v_o); the register may load when it is empty or when it transfers in the same cycle.
REQ-021 SHALL grant only when all three hold: the register may load, occupancy is below max_outstanding_p, and at least one req_cmd_v_i bit is set.
REQ-022 SHALL choose the grantee round-robin: priority starts at (last_grant+1) mod num_req_p and ascends with wrap; last_grant resets to num_req_p-1, so requester 0 has first priority.
REQ-023 SHALL load a granted command into the output register at the grant edge; latency from grant to io_cmd_v_o high is exactly 1 cycle; back-to-back grants sustain 1 command per cycle while io_cmd_ready_i stays high.
REQ-024 SHALL push the grantee index into the tag FIFO on the grant cycle, not on host acceptance.
REQ-025 SHALL hold io_cmd_o stable while io_cmd_v_o is high and io_cmd_ready_i is low.
REQ-026 SHALL pass io_resp_i combinationally to req_resp_o and assert req_resp_v_o[head_tag] when io_resp_v_i is high and the FIFO is non-empty.
REQ-027 SHALL set io_resp_yumi_o = req_resp_yumi_i[head_tag] when io_resp_v_i is high and the FIFO is non-empty, and pop the tag FIFO on that yumi.
REQ-028 SHALL treat a response arriving with the FIFO empty as an orphan: assert io_resp_yumi_o to drop it, keep req_resp_v_o at zero, and set orphan_resp_o until reset.
REQ-029 SHALL block a grant when occupancy equals max_outstanding_p, even if a pop occurs in the same cycle; this is a conservative full.
REQ-030 SHALL apply a simultaneous push and pop at non-full occupancy, leaving occupancy unchanged.
REQ-031 SHALL wrap the tag FIFO read and write pointers modulo max_outstanding_p.

Reset
REQ-032 SHALL, while reset_n_i is low, force io_cmd_v_o=0, req_cmd_yumi_o=0, req_resp_v_o=0, io_resp_yumi_o=0, outstanding_o=0, orphan_resp_o=0, last_grant=num_req_p-1, and FIFO pointers to 0, asynchronously.
REQ-033 SHALL discard any buffered command and outstanding tags when reset asserts mid-operation; the first grant after deassertion follows REQ-022.

Verification
REQ-034 SHALL be tested as follows: req_cmd_v_i=2'b11 held, io_cmd_ready_i=1 -> grants alternate 0,1,0,1; io_cmd_v_o first high 1 cycle after the first grant.
REQ-035 SHALL be tested as follows: io_cmd_ready_i=0 with requester 0 valid -> one grant, then the register is held with no further yumi; ready=1 -> transfer plus a new grant in the same cycle.
REQ-036 SHALL be tested as follows: issue 8 commands with no responses (max_outstanding_p=8) -> outstanding_o=8, no 9th grant; one response popped -> the next grant occurs on the following cycle.
REQ-037 SHALL be tested as follows: grants to 1,0,1, then 3 host responses -> req_resp_v_o=2'b10, 2'b01, 2'b10 in order; a yumi stall by requester 1 stalls io_resp_yumi_o.
REQ-038 SHALL be tested as follows: io_resp_v_i=1 with the FIFO empty -> io_resp_yumi_o=1, req_resp_v_o=0, orphan_resp_o=1 and held.
REQ-039 SHALL be tested as follows: assert reset_n_i low while 3 commands are outstanding -> all outputs are 0 immediately (asynchronously), outstanding_o=0, and the first grant after release goes to requester 0.
